// File: rtl/t10_lcd_pkg.sv
// Shared types, LCD command bytes and sizing helpers for the t10 LCD controller.
// The optional T10_LCD_AUTO_REFRESH_EN build changes only the top level.
package t10_lcd_pkg;

    typedef enum logic [1:0] {
        POWERUP,
        INIT,
        IDLE,
        FRAME
    } lcd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_WAIT
    } wr_phase_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam int unsigned FRAME_BYTES = 34;
    localparam int unsigned INIT_BYTES  = 4;

    localparam logic [127:0] BLANK_LINE = {16{8'h20}};

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Power-up command order expected by the panel.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_CLEAR;
            default: cmd = CMD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/t10_lcd_if.sv
// Host-side and panel-side signal bundle of the t10 LCD controller.
// master = host/display logic, slave = the controller.
interface t10_lcd_if;
    import t10_lcd_pkg::*;

    logic [127:0] top;
    logic [127:0] bottom;
    logic         update;
    logic         busy;
    logic         done;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_en;
    logic [7:0]   lcd_data;

    modport master (
        output top, bottom, update,
        input  busy, done, lcd_rs, lcd_rw, lcd_en, lcd_data
    );

    modport slave (
        input  top, bottom, update,
        output busy, done, lcd_rs, lcd_rw, lcd_en, lcd_data
    );

endinterface

// File: rtl/t10_lcd_byte_writer.sv
// Writes one byte to the panel: setup with en low, enable pulse, then settle wait.
// done is raised in the last wait cycle so a back-to-back start has no gap.
module t10_lcd_byte_writer #(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EN_PULSE_CYC   = 5,
    parameter int unsigned CMD_WAIT_CYC   = 400,
    parameter int unsigned CLEAR_WAIT_CYC = 16000,
    parameter int unsigned CW             = 18
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);
    import t10_lcd_pkg::*;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(EN_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);

    wr_phase_e     phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          long_q, long_d;
    logic [CW-1:0] wait_last;
    logic          accept;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            phase_q <= W_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        long_d  = long_q;
        accept  = start && ((phase_q == W_IDLE) || done);
        if (accept) begin
            phase_d = W_SETUP;
            cnt_d   = '0;
            rs_d    = rs;
            data_d  = data;
            long_d  = long_wait;
        end else begin
            case (phase_q)
                W_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        phase_d = W_PULSE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                W_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        phase_d = W_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                W_WAIT: begin
                    if (done) begin
                        phase_d = W_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: phase_d = W_IDLE;
            endcase
        end
    end

    // rs/data stay registered across the whole byte; only en follows the phase.
    always_comb begin
        wait_last = long_q ? CLEAR_LAST : CMD_LAST;
        done      = (phase_q == W_WAIT) && (cnt_q == wait_last);
        en_d      = (phase_d == W_PULSE);
        lcd_en    = en_q;
        lcd_rs    = rs_q;
        lcd_data  = data_q;
    end

endmodule

// File: rtl/t10_lcd_ctrl.sv
// HD44780 16x2 sequencer: power-up wait, init commands, then 34-byte frame writes.
// Define T10_LCD_AUTO_REFRESH_EN to also start a frame when the line buffers change.
module t10_lcd_ctrl #(
    parameter int unsigned POWERUP_CYC    = 150000,
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EN_PULSE_CYC   = 5,
    parameter int unsigned CMD_WAIT_CYC   = 400,
    parameter int unsigned CLEAR_WAIT_CYC = 16000
) (
    input logic      clk,
    input logic      nRst,
    t10_lcd_if.slave bus
);
    import t10_lcd_pkg::*;

    localparam int unsigned CW = $clog2(max_u(max_u(POWERUP_CYC, CLEAR_WAIT_CYC),
                                              max_u(CMD_WAIT_CYC, max_u(SETUP_CYC, EN_PULSE_CYC))) + 1);
    localparam logic [CW-1:0] PWR_LAST       = CW'(POWERUP_CYC - 1);
    localparam logic [5:0]    LAST_FRAME_IDX = 6'(FRAME_BYTES - 1);
    localparam logic [5:0]    LAST_INIT_IDX  = 6'(INIT_BYTES - 1);

    lcd_state_e    state_q, state_d;
    logic [CW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [5:0]    idx_q, idx_d;
    logic          pending_q, pending_d;
    logic          done_q, done_d;
    logic [127:0]  snap_top_q, snap_top_d;
    logic [127:0]  snap_bot_q, snap_bot_d;

    logic [5:0]    idx_nxt;
    logic          wr_start;
    logic          wr_rs;
    logic [7:0]    wr_data;
    logic          wr_long;
    logic          wr_done;
    logic          content_changed;
    logic          refresh_req;

    // Character k of a line, k = 0 being the leftmost ([127:120]).
    function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] k);
        logic [127:0] shifted;
        shifted = line << {k, 3'b000};
        return shifted[127:120];
    endfunction

    // {rs, byte} for position n of a frame.
    function automatic logic [8:0] frame_byte(input logic [5:0] n,
                                              input logic [127:0] line1,
                                              input logic [127:0] line2);
        logic [8:0] b;
        if (n == 6'd0)
            b = {1'b0, CMD_LINE1};
        else if (n <= 6'd16)
            b = {1'b1, char_at(line1, 4'(n - 6'd1))};
        else if (n == 6'd17)
            b = {1'b0, CMD_LINE2};
        else
            b = {1'b1, char_at(line2, 4'(n - 6'd18))};
        return b;
    endfunction

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= POWERUP;
            pwr_cnt_q  <= '0;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
            snap_top_q <= BLANK_LINE;
            snap_bot_q <= BLANK_LINE;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            snap_top_q <= snap_top_d;
            snap_bot_q <= snap_bot_d;
        end
    end

`ifdef T10_LCD_AUTO_REFRESH_EN
    always_comb content_changed = (bus.top != snap_top_q) || (bus.bottom != snap_bot_q);
`else
    always_comb content_changed = 1'b0;
`endif

    // The next byte is issued in the same cycle the current one reports done,
    // so every byte follows its predecessor without an idle cycle.
    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        done_d      = 1'b0;
        snap_top_d  = snap_top_q;
        snap_bot_d  = snap_bot_q;
        wr_start    = 1'b0;
        wr_rs       = 1'b0;
        wr_data     = '0;
        idx_nxt     = idx_q + 6'd1;
        refresh_req = bus.update || pending_q || content_changed;

        if (bus.update && (state_q != IDLE))
            pending_d = 1'b1;

        case (state_q)
            POWERUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d  = INIT;
                    idx_d    = '0;
                    wr_start = 1'b1;
                    wr_data  = init_cmd(2'd0);
                end else begin
                    pwr_cnt_d = pwr_cnt_q + CW'(1);
                end
            end
            INIT: begin
                if (wr_done) begin
                    if (idx_q == LAST_INIT_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d    = idx_nxt;
                        wr_start = 1'b1;
                        wr_data  = init_cmd(idx_nxt[1:0]);
                    end
                end
            end
            IDLE: begin
                if (refresh_req) begin
                    snap_top_d        = bus.top;
                    snap_bot_d        = bus.bottom;
                    pending_d         = 1'b0;
                    state_d           = FRAME;
                    idx_d             = '0;
                    wr_start          = 1'b1;
                    {wr_rs, wr_data}  = frame_byte(6'd0, bus.top, bus.bottom);
                end
            end
            FRAME: begin
                if (wr_done) begin
                    if (idx_q == LAST_FRAME_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d            = idx_nxt;
                        wr_start         = 1'b1;
                        {wr_rs, wr_data} = frame_byte(idx_nxt, snap_top_q, snap_bot_q);
                    end
                end
            end
            default: state_d = POWERUP;
        endcase
    end

    always_comb begin
        wr_long    = !wr_rs && (wr_data == CMD_CLEAR);
        bus.busy   = (state_q != IDLE);
        bus.done   = done_q;
        bus.lcd_rw = 1'b0;
    end

    t10_lcd_byte_writer #(
        .SETUP_CYC      (SETUP_CYC),
        .EN_PULSE_CYC   (EN_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
        .CW             (CW)
    ) u_writer (
        .clk       (clk),
        .nRst      (nRst),
        .start     (wr_start),
        .rs        (wr_rs),
        .data      (wr_data),
        .long_wait (wr_long),
        .done      (wr_done),
        .lcd_en    (bus.lcd_en),
        .lcd_rs    (bus.lcd_rs),
        .lcd_data  (bus.lcd_data)
    );

endmodule

// File: tb/tb_t10_lcd_ctrl.sv
// Directed/randomised bench for t10_lcd_ctrl; expected panel traffic is rebuilt
// from the line buffers and byte timing rules. Honours T10_LCD_AUTO_REFRESH_EN.
module tb_t10_lcd_ctrl;

    localparam int unsigned P_PWR = 20;
    localparam int unsigned P_SU  = 1;
    localparam int unsigned P_EN  = 2;
    localparam int unsigned P_CW  = 3;
    localparam int unsigned P_CLR = 10;
    localparam int unsigned BYTE_LEN  = P_SU + P_EN + P_CW;
    localparam int unsigned FRAME_LEN = 34 * BYTE_LEN;
    localparam logic [127:0] SPACES = {16{8'h20}};

    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    t10_lcd_if bus();

    t10_lcd_ctrl #(
        .POWERUP_CYC    (P_PWR),
        .SETUP_CYC      (P_SU),
        .EN_PULSE_CYC   (P_EN),
        .CMD_WAIT_CYC   (P_CW),
        .CLEAR_WAIT_CYC (P_CLR)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    // Panel monitor: start cycle, {rs,data} and width of every enable pulse.
    int unsigned pc[$];
    logic [8:0]  pd[$];
    int unsigned pw[$];
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned hi_len = 0;
    logic        en_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.lcd_en === 1'b1) begin
            if (!en_prev) begin
                pc.push_back(cyc);
                pd.push_back({bus.lcd_rs, bus.lcd_data});
            end
            hi_len = hi_len + 1;
        end else begin
            if (en_prev) pw.push_back(hi_len);
            hi_len = 0;
        end
        if (bus.done === 1'b1) done_cnt = done_cnt + 1;
        en_prev = (bus.lcd_en === 1'b1);
    end

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    logic [8:0]  expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        pc.delete();
        pd.delete();
        pw.delete();
    endtask

    function automatic logic [127:0] rand_line();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v = {v[119:0], 8'($urandom_range(33, 126))};
        return v;
    endfunction

    function automatic logic [7:0] init_ref(input int unsigned i);
        case (i)
            0: return 8'h38;
            1: return 8'h0C;
            2: return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    task automatic wait_done(input int unsigned bound, output int unsigned at);
        bit seen;
        seen = 1'b0;
        at = 0;
        for (int unsigned i = 0; i < bound && !seen; i++) begin
            step();
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        if (!seen) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    // rel = cycle in which nRst was released.
    task automatic check_init(input int unsigned rel, input string tag);
        bit seen;
        int unsigned fall;
        int unsigned off;
        seen = 1'b0;
        fall = 0;
        for (int unsigned i = 0; i < 400 && !seen; i++) begin
            step();
            if (bus.busy === 1'b0) begin
                seen = 1'b1;
                fall = cyc;
            end
        end
        if (!seen) chk({tag, "_busy_timeout"}, 32'(bus.busy), 32'd0);
        chk({tag, "_npulse"}, 32'(pc.size()), 32'd4);
        off = P_PWR + P_SU;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < pc.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), 32'(pd[i]), 32'({1'b0, init_ref(i)}));
                chk($sformatf("%s_at%0d", tag, i), pc[i], rel + off);
            end
            if (i < pw.size()) chk($sformatf("%s_width%0d", tag, i), pw[i], P_EN);
            off = off + P_SU + P_EN + ((init_ref(i) == 8'h01) ? P_CLR : P_CW);
        end
        chk({tag, "_busy_fall"}, fall, rel + off - P_SU);
    endtask

    task automatic check_frame(input logic [127:0] t, input logic [127:0] b,
                               input int unsigned base, input int unsigned first, input string tag);
        expq.delete();
        expq.push_back({1'b0, 8'h80});
        for (int unsigned i = 0; i < 16; i++) expq.push_back({1'b1, 8'(t >> (8 * (15 - i)))});
        expq.push_back({1'b0, 8'hC0});
        for (int unsigned i = 0; i < 16; i++) expq.push_back({1'b1, 8'(b >> (8 * (15 - i)))});
        for (int unsigned i = 0; i < 34; i++) begin
            if (base + i < pc.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), 32'(pd[base + i]), 32'(expq[i]));
                chk($sformatf("%s_at%0d", tag, i), pc[base + i], first + i * BYTE_LEN);
            end
        end
    endtask

    logic [127:0] t0, t1, t2, b0, b1;
    int unsigned  n, d, d2, rel, dc0;
    bit           reached;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0;
        bus.update = 1'b0;
        bus.top = SPACES;
        bus.bottom = SPACES;
        repeat (3) step();

        chk("rst_en",   32'(bus.lcd_en),   32'd0);
        chk("rst_rs",   32'(bus.lcd_rs),   32'd0);
        chk("rst_rw",   32'(bus.lcd_rw),   32'd0);
        chk("rst_data", 32'(bus.lcd_data), 32'd0);
        chk("rst_busy", 32'(bus.busy),     32'd1);
        chk("rst_done", 32'(bus.done),     32'd0);

        // Power-up and init sequence.
        clear_mon();
        nRst = 1'b1;
        rel = cyc;
        check_init(rel, "init1");

        // Single frame with "  Win  " at the left of line 1.
        repeat (5) step();
        t0 = rand_line();
        t0[127:72] = 56'h2020_5769_6E20_20;
        b0 = rand_line();
        b0[7:0] = 8'h5F;
        clear_mon();
        dc0 = done_cnt;
        bus.top = t0;
        bus.bottom = b0;
        bus.update = 1'b1;
        n = cyc;
        step();
        bus.update = 1'b0;
        chk("f1_busy", 32'(bus.busy), 32'd1);
        wait_done(400, d);
        chk("f1_done_at", d, n + 1 + FRAME_LEN);
        step();
        chk("f1_done_1cyc", 32'(bus.done), 32'd0);
        chk("f1_npulse", 32'(pc.size()), 32'd34);
        chk("f1_ndone", done_cnt - dc0, 32'd1);
        check_frame(t0, b0, 0, n + 2, "f1");

        // Two requests during a frame coalesce into one frame with the latest top.
        repeat (3) step();
        t0 = rand_line();
        clear_mon();
        dc0 = done_cnt;
        bus.top = t0;
        bus.update = 1'b1;
        n = cyc;
        step();
        bus.update = 1'b0;
        repeat (40) step();
        t1 = rand_line();
        bus.top = t1;
        bus.update = 1'b1;
        step();
        bus.update = 1'b0;
        repeat (30) step();
        t2 = rand_line();
        bus.top = t2;
        bus.update = 1'b1;
        step();
        bus.update = 1'b0;
        wait_done(400, d);
        chk("f2_done_at", d, n + 1 + FRAME_LEN);
        wait_done(400, d2);
        chk("f3_done_at", d2, d + 1 + FRAME_LEN);
        repeat (300) step();
        chk("f23_npulse", 32'(pc.size()), 32'd68);
        chk("f23_ndone", done_cnt - dc0, 32'd2);
        check_frame(t0, b0, 0, n + 2, "f2");
        check_frame(t2, b0, 34, d + 2, "f3");

        // Request in the done cycle starts the next frame straight away.
        t0 = rand_line();
        clear_mon();
        bus.top = t0;
        bus.update = 1'b1;
        n = cyc;
        step();
        bus.update = 1'b0;
        wait_done(400, d);
        t1 = rand_line();
        bus.top = t1;
        bus.update = 1'b1;
        step();
        bus.update = 1'b0;
        chk("f5_busy_next", 32'(bus.busy), 32'd1);
        chk("f4_done_1cyc", 32'(bus.done), 32'd0);
        wait_done(400, d2);
        chk("f5_done_at", d2, d + 1 + FRAME_LEN);
        chk("f45_npulse", 32'(pc.size()), 32'd68);
        check_frame(t0, b0, 0, n + 2, "f4");
        check_frame(t1, b0, 34, d + 2, "f5");

        // Reset while byte 10 of a frame is on the bus.
        repeat (3) step();
        clear_mon();
        bus.top = rand_line();
        bus.update = 1'b1;
        step();
        bus.update = 1'b0;
        reached = 1'b0;
        for (int unsigned i = 0; i < 200 && !reached; i++) begin
            if (pc.size() >= 11) reached = 1'b1;
            else step();
        end
        chk("mid_reached", 32'(pc.size() >= 11), 32'd1);
        chk("mid_en_before", 32'(bus.lcd_en), 32'd1);
        nRst = 1'b0;
        #1;
        chk("mid_rst_en",   32'(bus.lcd_en),   32'd0);
        chk("mid_rst_rs",   32'(bus.lcd_rs),   32'd0);
        chk("mid_rst_data", 32'(bus.lcd_data), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy),     32'd1);
        chk("mid_rst_done", 32'(bus.done),     32'd0);
        bus.top = SPACES;
        bus.bottom = SPACES;
        repeat (3) step();
        clear_mon();
        nRst = 1'b1;
        rel = cyc;
        check_init(rel, "init2");

        // Buffer change in IDLE without a request.
        t0 = rand_line();
        b0 = rand_line();
        b0[7:0] = 8'h5F;
        clear_mon();
        bus.top = t0;
        bus.bottom = b0;
        bus.update = 1'b1;
        n = cyc;
        step();
        bus.update = 1'b0;
        wait_done(400, d);
        chk("f6_done_at", d, n + 1 + FRAME_LEN);
        repeat (20) step();
        clear_mon();
        dc0 = done_cnt;
        b1 = b0;
        b1[7:0] = 8'h41;
        bus.bottom = b1;
        n = cyc;
        repeat (300) step();
`ifdef T10_LCD_AUTO_REFRESH_EN
        chk("auto_npulse", 32'(pc.size()), 32'd34);
        chk("auto_ndone", done_cnt - dc0, 32'd1);
        check_frame(t0, b1, 0, n + 2, "auto");
`else
        chk("auto_npulse", 32'(pc.size()), 32'd0);
        chk("auto_ndone", done_cnt - dc0, 32'd0);
`endif
        chk("auto_idle_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/t10_lcd_ctrl.md
Name: t10_lcd_ctrl

Overview:
Sequencer that drives the 16x2 HD44780-style character LCD from the host display's 128-bit top/bottom line buffers (16 ASCII chars each; bits [127:120] are the leftmost char). It runs the LCD power-up init sequence, then on request snapshots both lines and streams them to the panel with correct enable-pulse timing. It sits between the host/player display blocks and the LCD pins.

Parameters:
POWERUP_CYC, 150000, clk cycles to wait after reset before the first command (15 ms @ 10 MHz)
SETUP_CYC, 2, cycles rs/data stable with lcd_en low before the pulse
EN_PULSE_CYC, 5, cycles lcd_en held high
CMD_WAIT_CYC, 400, cycles after the pulse for normal commands/data (40 us)
CLEAR_WAIT_CYC, 16000, cycles after the pulse for clear command 0x01 (1.6 ms)

Ports:
clk  input  1  system clock
nRst  input  1  reset; asynchronous, active-low
top  input  128  line-1 chars, MSB char first
bottom  input  128  line-2 chars, MSB char first
update  input  1  single-cycle refresh request
busy  output  1  high while init or a frame write is in progress
done  output  1  one-cycle pulse when a frame write completes
lcd_rs  output  1  0 = command, 1 = data
lcd_rw  output  1  tied 0 (write only)
lcd_en  output  1  enable strobe
lcd_data  output  8  byte to panel

Behaviour:
- Reset: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, busy=1, done=0, pending=0, snapshots cleared to 0x20; state POWERUP. Reset mid-operation aborts everything and restarts POWERUP.
- States: POWERUP -> INIT -> IDLE -> FRAME -> IDLE.
- POWERUP: counter runs POWERUP_CYC cycles, then INIT.
- INIT: commands in order 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x01 (clear, uses CLEAR_WAIT_CYC), 0x06 (entry increment). After last byte -> IDLE, busy=0.
- Byte timing (every byte): SETUP_CYC cycles en=0 with rs/data driven; EN_PULSE_CYC cycles en=1; then wait cycles (CMD_WAIT_CYC, or CLEAR_WAIT_CYC for 0x01) en=0, rs/data held. Byte occupies SETUP+PULSE+WAIT cycles; next byte's setup begins the following cycle.
- IDLE: when update=1 (or pending=1), latch top/bottom into snapshots that same edge; next cycle busy=1, state FRAME.
- FRAME: 34 bytes: 0x80 (rs=0), top chars 15..0 i.e. [127:120] first (rs=1), 0xC0 (rs=0), bottom chars (rs=1). 6-bit byte index 0..33. After byte 33 wait completes: done=1 for one cycle, busy=0, state IDLE.
- update during POWERUP/INIT/FRAME: set pending (multiple requests coalesce to one). Snapshot unchanged mid-frame; frame in progress completes with old data. pending cleared when the next frame latches.
- update in the same cycle FRAME finishes: sets pending; new frame starts from IDLE next cycle.
- Counters sized $clog2 of max(POWERUP_CYC, CLEAR_WAIT_CYC)+1; all parameters >= 1.

Optional Feature:
T10_LCD_AUTO_REFRESH_EN: when defined, IDLE also starts a frame whenever top or bottom differs from the last-written snapshots (compare each cycle in IDLE; changes while busy are caught on return to IDLE). When undefined, frames start only from update/pending; no comparator logic synthesized.

Decomposition:
- Package t10_lcd_pkg: state enum (POWERUP, INIT, IDLE, FRAME), command constants (CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06, CMD_LINE1=0x80, CMD_LINE2=0xC0), FRAME_BYTES=34.
- Sub-module t10_lcd_byte_writer: start/rs/data/long_wait in, done out; owns setup/pulse/wait counter and lcd_en/rs/data registers. Top level sequences bytes.

Test Plan:
(Bench params: POWERUP_CYC=20, SETUP_CYC=1, EN_PULSE_CYC=2, CMD_WAIT_CYC=3, CLEAR_WAIT_CYC=10.)
- Release nRst -> no en pulse for 20 cycles; then exactly 4 en pulses carrying 0x38,0x0C,0x01,0x06 with rs=0; gap after 0x01 is 10 cycles; busy falls after the 0x06 wait.
- top="  Win  ..." (0x20,0x20,0x57,...), update pulse in IDLE -> 34 pulses: 0x80, 16 top bytes in MSB-first order with rs=1, 0xC0, 16 bottom bytes; frame length 34*6=204 cycles; done pulses once.
- Two update pulses during a frame, top changed between them -> exactly one more frame after done, carrying the latest top; first frame carries the original snapshot.
- Assert nRst at byte 10 of a frame -> outputs return to reset values immediately; POWERUP/INIT sequence repeats fully.
- update coincident with final done cycle -> second frame begins the next cycle.
- With T10_LCD_AUTO_REFRESH_EN: change bottom[7:0] from 0x5F to 0x41 in IDLE, no update -> one frame written, then idle with no further frames while inputs are stable; without the macro -> no frame.
